// File: rtl/cache_hit_profiler.sv
// Set-associative cache hit profiler with true-LRU replacement and saturating
// hit/miss/access counters, fed by a valid/ready trace-address stream.
//
// state  | meaning
// IDLE   | ready for a trace address; services flush
// LOOKUP | tag compare on the latched address, pick hit way or victim
// UPDATE | fill victim on miss, age the set, commit result and counters
module cache_hit_profiler #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 4,
  parameter int WAYS     = 2,
  parameter int CNT_W    = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              trace_valid_i,
  output logic              trace_ready_o,
  input  logic [ADDR_W-1:0] trace_addr_i,
  output logic              updated_o,
  output logic              hit_o,
  output logic [CNT_W-1:0]  hit_count_o,
  output logic [CNT_W-1:0]  miss_count_o,
  output logic [CNT_W-1:0]  access_count_o
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;
  // WAYS=1 keeps a 1-bit age that is always 0
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_t;

  state_t state_q, state_d;
  logic [ADDR_W-OFFSET_W-1:0] line_q, line_d;
  logic [AGE_W-1:0] way_q, way_d;
  logic lhit_q, lhit_d;
  logic hit_q, hit_d;
  logic updated_q, updated_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d, mcnt_q, mcnt_d, acnt_q, acnt_d;
  logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0] age_q, age_d;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic lk_hit, lk_found_inv;
  logic [AGE_W-1:0] lk_way;
  logic [AGE_W-1:0] r_age;
  logic unused_offset;

  assign unused_offset = ^trace_addr_i[OFFSET_W-1:0];
  assign idx = line_q[INDEX_W-1:0];
  assign tag = line_q[ADDR_W-OFFSET_W-1:INDEX_W];

  // Hit way first; otherwise lowest invalid way; otherwise the oldest way
  always_comb begin
    lk_hit       = 1'b0;
    lk_found_inv = 1'b0;
    lk_way       = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!lk_hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        lk_hit = 1'b1;
        lk_way = AGE_W'(w);
      end
    end
    if (!lk_hit) begin
      for (int w = 0; w < WAYS; w++) begin
        if (!lk_found_inv && !valid_q[idx][w]) begin
          lk_found_inv = 1'b1;
          lk_way       = AGE_W'(w);
        end
      end
      if (!lk_found_inv) begin
        for (int w = 0; w < WAYS; w++) begin
          if (age_q[idx][w] == AGE_W'(WAYS - 1)) lk_way = AGE_W'(w);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    way_d     = way_q;
    lhit_d    = lhit_q;
    hit_d     = hit_q;
    updated_d = 1'b0;
    hcnt_d    = hcnt_q;
    mcnt_d    = mcnt_q;
    acnt_d    = acnt_q;
    valid_d   = valid_q;
    tag_d     = tag_q;
    age_d     = age_q;
    r_age     = age_q[idx][way_q];
    case (state_q)
      IDLE: begin
        if (flush_i) begin
          valid_d = '0;
          hcnt_d  = '0;
          mcnt_d  = '0;
          acnt_d  = '0;
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) age_d[s][w] = AGE_W'(w);
        end else if (trace_valid_i) begin
          line_d  = trace_addr_i[ADDR_W-1:OFFSET_W];
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        lhit_d  = lk_hit;
        way_d   = lk_way;
        state_d = UPDATE;
      end
      UPDATE: begin
        if (!lhit_q) begin
          valid_d[idx][way_q] = 1'b1;
          tag_d[idx][way_q]   = tag;
        end
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == way_q) age_d[idx][w] = '0;
          else if (age_q[idx][w] < r_age) age_d[idx][w] = age_q[idx][w] + 1'b1;
        end
        hit_d     = lhit_q;
        updated_d = 1'b1;
        if (acnt_q != CNT_MAX) acnt_d = acnt_q + 1'b1;
        if (lhit_q) begin
          if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 1'b1;
        end else begin
          if (mcnt_q != CNT_MAX) mcnt_d = mcnt_q + 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      line_q    <= '0;
      way_q     <= '0;
      lhit_q    <= 1'b0;
      hit_q     <= 1'b0;
      updated_q <= 1'b0;
      hcnt_q    <= '0;
      mcnt_q    <= '0;
      acnt_q    <= '0;
      valid_q   <= '0;
      tag_q     <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      way_q     <= way_d;
      lhit_q    <= lhit_d;
      hit_q     <= hit_d;
      updated_q <= updated_d;
      hcnt_q    <= hcnt_d;
      mcnt_q    <= mcnt_d;
      acnt_q    <= acnt_d;
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      age_q     <= age_d;
    end
  end

  assign trace_ready_o  = (state_q == IDLE) && !flush_i;
  assign updated_o      = updated_q;
  assign hit_o          = hit_q;
  assign hit_count_o    = hcnt_q;
  assign miss_count_o   = mcnt_q;
  assign access_count_o = acnt_q;

endmodule

// File: tb/tb_cache_hit_profiler.sv
// Directed bench for cache_hit_profiler: a default instance plus a CNT_W=4
// instance for counter saturation.
module tb_cache_hit_profiler;

  logic clk = 1'b0;
  logic rst_n;
  logic flush, tv;
  logic [31:0] addr;
  logic ready, upd, hit;
  logic [9:0] hcnt, mcnt, acnt;

  logic flush1, tv1;
  logic [31:0] addr1;
  logic ready1, upd1, hit1;
  logic [3:0] hcnt1, mcnt1, acnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_hit_profiler dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .trace_valid_i(tv),
    .trace_ready_o(ready), .trace_addr_i(addr), .updated_o(upd), .hit_o(hit),
    .hit_count_o(hcnt), .miss_count_o(mcnt), .access_count_o(acnt)
  );

  cache_hit_profiler #(.CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush1), .trace_valid_i(tv1),
    .trace_ready_o(ready1), .trace_addr_i(addr1), .updated_o(upd1), .hit_o(hit1),
    .hit_count_o(hcnt1), .miss_count_o(mcnt1), .access_count_o(acnt1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one address from IDLE and return in its commit cycle
  task automatic send(input logic [31:0] a);
    tv = 1'b1;
    addr = a;
    tick();
    tv = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_flush;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; tv = 1'b0; addr = '0;
    flush1 = 1'b0; tv1 = 1'b0; addr1 = '0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    checks++; if (hcnt !== 10'd0) begin errors++; $display("FAIL reset_hit_count got=%0d exp=0", hcnt); end
    checks++; if (mcnt !== 10'd0) begin errors++; $display("FAIL reset_miss_count got=%0d exp=0", mcnt); end
    checks++; if (acnt !== 10'd0) begin errors++; $display("FAIL reset_access_count got=%0d exp=0", acnt); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL reset_updated got=%b exp=0", upd); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b exp=0", hit); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
  endtask

  task automatic test_same_line;
    tv = 1'b1; addr = 32'h000;
    tick();
    tv = 1'b0;
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL timing_e0 updated got=%b exp=0", upd); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL busy_ready got=%b exp=0", ready); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL timing_e1 updated got=%b exp=0", upd); end
    tick();
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL timing_e2 updated got=%b exp=1", upd); end
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL first_access hit got=%b exp=0", hit); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL commit_ready got=%b exp=1", ready); end
    send(32'h004);
    checks++; if (upd !== 1'b1) begin errors++; $display("FAIL same_line updated got=%b exp=1", upd); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL same_line hit got=%b exp=1", hit); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL pulse_width updated got=%b exp=0", upd); end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_hold got=%b exp=1", hit); end
    checks++; if (hcnt !== 10'd1) begin errors++; $display("FAIL same_line hit_count got=%0d exp=1", hcnt); end
    checks++; if (mcnt !== 10'd1) begin errors++; $display("FAIL same_line miss_count got=%0d exp=1", mcnt); end
    checks++; if (acnt !== 10'd2) begin errors++; $display("FAIL same_line access_count got=%0d exp=2", acnt); end
  endtask

  task automatic test_flush;
    flush = 1'b1;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", ready); end
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    checks++; if (hcnt !== 10'd0 || mcnt !== 10'd0 || acnt !== 10'd0) begin
      errors++; $display("FAIL flush_counters got=%0d/%0d/%0d exp=0/0/0", hcnt, mcnt, acnt);
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL post_flush_ready got=%b exp=1", ready); end
    send(32'h000);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL flush_reaccess hit got=%b exp=0", hit); end
    checks++; if (mcnt !== 10'd1) begin errors++; $display("FAIL flush_reaccess miss_count got=%0d exp=1", mcnt); end
  endtask

  task automatic test_lru;
    logic [31:0] seq [5];
    logic exp_h [5];
    seq = '{32'h000, 32'h100, 32'h000, 32'h200, 32'h100};
    exp_h = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_flush();
    for (int i = 0; i < 5; i++) begin
      send(seq[i]);
      checks++; if (hit !== exp_h[i]) begin errors++; $display("FAIL lru_step%0d hit got=%b exp=%b", i, hit, exp_h[i]); end
    end
    checks++; if (hcnt !== 10'd1) begin errors++; $display("FAIL lru hit_count got=%0d exp=1", hcnt); end
    checks++; if (mcnt !== 10'd4) begin errors++; $display("FAIL lru miss_count got=%0d exp=4", mcnt); end
    checks++; if (acnt !== 10'd5) begin errors++; $display("FAIL lru access_count got=%0d exp=5", acnt); end
  endtask

  task automatic test_back_to_back;
    do_flush();
    tv = 1'b1; addr = 32'h000;
    tick(); tick(); tick();
    checks++; if (upd !== 1'b1 || hit !== 1'b0) begin errors++; $display("FAIL b2b_first got=upd%b/hit%b exp=upd1/hit0", upd, hit); end
    tick();
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL b2b_gap updated got=%b exp=0", upd); end
    tick(); tick();
    checks++; if (upd !== 1'b1 || hit !== 1'b1) begin errors++; $display("FAIL b2b_second got=upd%b/hit%b exp=upd1/hit1", upd, hit); end
    tv = 1'b0;
    tick(); tick(); tick();
    checks++; if (acnt !== 10'd2) begin errors++; $display("FAIL b2b access_count got=%0d exp=2", acnt); end
    checks++; if (upd !== 1'b0) begin errors++; $display("FAIL b2b_idle updated got=%b exp=0", upd); end
  endtask

  task automatic test_reset_mid;
    int upd_seen;
    upd_seen = 0;
    tv = 1'b1; addr = 32'h000;
    tick();
    tv = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (upd !== 1'b0 || acnt !== 10'd0) begin errors++; $display("FAIL mid_reset_async got=upd%b/acc%0d exp=upd0/acc0", upd, acnt); end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (upd !== 1'b0) upd_seen++;
    end
    checks++; if (upd_seen !== 0) begin errors++; $display("FAIL mid_reset_pulse got=%0d pulses exp=0", upd_seen); end
    checks++; if (hcnt !== 10'd0 || mcnt !== 10'd0 || acnt !== 10'd0) begin
      errors++; $display("FAIL mid_reset_counters got=%0d/%0d/%0d exp=0/0/0", hcnt, mcnt, acnt);
    end
    send(32'h000);
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL mid_reset_reaccess hit got=%b exp=0", hit); end
    checks++; if (mcnt !== 10'd1) begin errors++; $display("FAIL mid_reset_reaccess miss_count got=%0d exp=1", mcnt); end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) begin
      tv1 = 1'b1; addr1 = 32'h040;
      tick();
      tv1 = 1'b0;
      tick();
      tick();
      if (i == 15) begin
        checks++; if (hcnt1 !== 4'd15) begin errors++; $display("FAIL sat_at16 hit_count got=%0d exp=15", hcnt1); end
      end
    end
    checks++; if (mcnt1 !== 4'd1) begin errors++; $display("FAIL sat miss_count got=%0d exp=1", mcnt1); end
    checks++; if (hcnt1 !== 4'd15) begin errors++; $display("FAIL sat hit_count got=%0d exp=15", hcnt1); end
    checks++; if (acnt1 !== 4'd15) begin errors++; $display("FAIL sat access_count got=%0d exp=15", acnt1); end
  endtask

  initial begin
    test_reset();
    test_same_line();
    test_flush();
    test_lru();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
